// File: rtl/pc_sequencer.sv
// Fetch-stage next-PC sequencer: seq / branch / jump / jump-reg / call / return / redirect.
// Latency: one cycle from sampled inputs to pc; link_pc is combinational from pc.
// Backpressure: stall holds pc and RAS state; redirect_valid overrides stall. RAS built only with PC_SEQ_RAS_EN.
module pc_sequencer #(
  parameter int              PC_W       = 32,
  parameter logic [PC_W-1:0] RESET_VEC  = '0,
  parameter int              INST_ALIGN = 2,
  parameter int              RAS_DEPTH  = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [PC_W-1:0] redirect_pc,
  input  logic [2:0]      pc_sel,
  input  logic            br_cond,
  input  logic [31:0]     inst,
  input  logic [PC_W-1:0] rs_val,
  output logic [PC_W-1:0] pc,
  output logic [PC_W-1:0] link_pc,
  output logic            ras_empty,
  output logic            ras_full,
  output logic            ras_err
);

  localparam logic [PC_W-1:0] INC        = PC_W'(1) << INST_ALIGN;
  localparam logic [PC_W-1:0] ALIGN_MASK = ~(INC - PC_W'(1));
  // Low bits of the PC replaced by the 26-bit jump index plus alignment zeros.
  localparam logic [PC_W-1:0] JMP_LOW    = (PC_W'(1) << (26 + INST_ALIGN)) - PC_W'(1);

  logic [PC_W-1:0] br_off;
  logic [PC_W-1:0] jmp_tgt;
  logic [PC_W-1:0] jr_tgt;
  logic [PC_W-1:0] nxt_pc;
  logic            adv;
  logic            unused_inst;

  assign link_pc     = pc + INC;
  assign br_off      = {{(PC_W-16){inst[15]}}, inst[15:0]} << INST_ALIGN;
  assign jmp_tgt     = (link_pc & ~JMP_LOW) | (PC_W'(inst[25:0]) << INST_ALIGN);
  assign jr_tgt      = rs_val & ALIGN_MASK;
  // A cycle only advances sequencing state when neither held nor redirected.
  assign adv         = !redirect_valid && !stall;
  assign unused_inst = ^inst[31:26];

`ifdef PC_SEQ_RAS_EN
  localparam int             PTR_W    = $clog2(RAS_DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(RAS_DEPTH);

  logic [PC_W-1:0]  ras_mem [RAS_DEPTH];
  logic [PTR_W-1:0] top_ptr;
  logic [PTR_W:0]   ras_cnt;
  logic [PTR_W:0]   push_cnt;
  logic             do_push;
  logic             do_pop;
  logic             ret_empty;

  // A push onto a full stack overwrites the oldest slot, so the count saturates.
  assign push_cnt = (ras_cnt == FULL_CNT) ? FULL_CNT : ras_cnt + (PTR_W+1)'(1);
`endif

  // Next-PC selection for an un-stalled, un-redirected cycle.
  always_comb begin
    nxt_pc = link_pc;
`ifdef PC_SEQ_RAS_EN
    do_push   = 1'b0;
    do_pop    = 1'b0;
    ret_empty = 1'b0;
`endif
    case (pc_sel)
      3'd1: if (br_cond) nxt_pc = link_pc + br_off;
      3'd2: nxt_pc = jmp_tgt;
      3'd3: nxt_pc = jr_tgt;
`ifdef PC_SEQ_RAS_EN
      3'd4: begin
        nxt_pc  = jmp_tgt;
        do_push = 1'b1;
      end
      3'd5: begin
        if (ras_cnt == '0) begin
          nxt_pc    = jr_tgt;
          ret_empty = 1'b1;
        end else begin
          nxt_pc = ras_mem[top_ptr];
          do_pop = 1'b1;
        end
      end
`else
      3'd4: nxt_pc = jmp_tgt;
      3'd5: nxt_pc = jr_tgt;
`endif
      default: nxt_pc = link_pc;
    endcase
  end

  // PC register: redirect beats stall, stall beats normal sequencing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= RESET_VEC;
    end else if (redirect_valid) begin
      pc <= redirect_pc;
    end else if (!stall) begin
      pc <= nxt_pc;
    end
  end

`ifdef PC_SEQ_RAS_EN
  // RAS pointer, count and registered status flags; ras_err is a single-cycle pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      top_ptr   <= '0;
      ras_cnt   <= '0;
      ras_empty <= 1'b1;
      ras_full  <= 1'b0;
      ras_err   <= 1'b0;
    end else begin
      ras_err <= adv && ret_empty;
      if (adv && do_push) begin
        top_ptr   <= top_ptr + PTR_W'(1);
        ras_cnt   <= push_cnt;
        ras_empty <= 1'b0;
        ras_full  <= (push_cnt == FULL_CNT);
      end else if (adv && do_pop) begin
        top_ptr   <= top_ptr - PTR_W'(1);
        ras_cnt   <= ras_cnt - (PTR_W+1)'(1);
        ras_empty <= (ras_cnt == (PTR_W+1)'(1));
        ras_full  <= 1'b0;
      end
    end
  end

  // RAS storage has no reset; entries are only meaningful below the count.
  always_ff @(posedge clk) begin
    if (rst_n && adv && do_push) begin
      ras_mem[top_ptr + PTR_W'(1)] <= link_pc & ALIGN_MASK;
    end
  end
`else
  assign ras_empty = 1'b1;
  assign ras_full  = 1'b0;
  assign ras_err   = 1'b0;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed scenarios plus randomized traffic against a queue-based model.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic [2:0]  pc_sel = '0;
  logic        br_cond = 1'b0;
  logic [31:0] inst = '0;
  logic [31:0] rs_val = '0;
  logic [31:0] pc;
  logic [31:0] link_pc;
  logic        ras_empty;
  logic        ras_full;
  logic        ras_err;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  logic [31:0] m_pc;
  logic [31:0] m_ras[$];
  bit          m_err;

  pc_sequencer #(
    .PC_W(32), .RESET_VEC(32'h0000_0100), .INST_ALIGN(2), .RAS_DEPTH(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .pc_sel(pc_sel), .br_cond(br_cond), .inst(inst),
    .rs_val(rs_val), .pc(pc), .link_pc(link_pc), .ras_empty(ras_empty),
    .ras_full(ras_full), .ras_err(ras_err)
  );

  always #5 clk = ~clk;

  function automatic bit m_empty();
`ifdef PC_SEQ_RAS_EN
    return m_ras.size() == 0;
`else
    return 1'b1;
`endif
  endfunction

  function automatic bit m_full();
`ifdef PC_SEQ_RAS_EN
    return m_ras.size() == 4;
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_reset();
    m_pc = 32'h100;
    m_ras.delete();
    m_err = 1'b0;
  endtask

  // Compute the architectural next state from the current inputs, then take one edge.
  task automatic tick();
    logic [31:0] lk;
    logic [31:0] nx;
    int off;
    lk    = m_pc + 32'd4;
    nx    = m_pc;
    m_err = 1'b0;
    off   = $signed(inst[15:0]);
    if (redirect_valid) begin
      nx = redirect_pc;
    end else if (!stall) begin
      case (pc_sel)
        3'd1: nx = br_cond ? lk + 32'(off * 4) : lk;
        3'd2: nx = (lk & 32'hF000_0000) | (inst[25:0] * 4);
        3'd3: nx = rs_val & ~32'd3;
`ifdef PC_SEQ_RAS_EN
        3'd4: begin
          nx = (lk & 32'hF000_0000) | (inst[25:0] * 4);
          m_ras.push_back(lk & ~32'd3);
          if (m_ras.size() > 4) void'(m_ras.pop_front());
        end
        3'd5: begin
          if (m_ras.size() == 0) begin
            nx = rs_val & ~32'd3;
            m_err = 1'b1;
          end else begin
            nx = m_ras.pop_back();
          end
        end
`else
        3'd4: nx = (lk & 32'hF000_0000) | (inst[25:0] * 4);
        3'd5: nx = rs_val & ~32'd3;
`endif
        default: nx = lk;
      endcase
    end
    @(posedge clk);
    #1;
    m_pc = nx;
  endtask

  task automatic go_to(input logic [31:0] addr);
    stall = 1'b0; redirect_valid = 1'b1; redirect_pc = addr;
    tick();
    redirect_valid = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] exp_seq [3];
    exp_seq = '{32'h104, 32'h108, 32'h10C};
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (pc !== 32'h100) begin n_bad++; $display("FAIL reset_pc got=%h want=%h", pc, 32'h100); end
    n_cmp++; if (ras_empty !== 1'b1) begin n_bad++; $display("FAIL reset_empty got=%b want=1", ras_empty); end
    n_cmp++; if (ras_full !== 1'b0) begin n_bad++; $display("FAIL reset_full got=%b want=0", ras_full); end
    n_cmp++; if (ras_err !== 1'b0) begin n_bad++; $display("FAIL reset_err got=%b want=0", ras_err); end
    rst_n = 1'b1;
    pc_sel = 3'd0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++; if (pc !== exp_seq[i]) begin n_bad++; $display("FAIL reset_seq%0d got=%h want=%h", i, pc, exp_seq[i]); end
    end
  endtask

  task automatic test_branch_stall();
    go_to(32'h200);
    pc_sel = 3'd1; br_cond = 1'b1; inst = 32'h0000_FFFE;
    tick();
    n_cmp++; if (pc !== 32'h1FC) begin n_bad++; $display("FAIL br_taken got=%h want=%h", pc, 32'h1FC); end
    go_to(32'h200);
    pc_sel = 3'd1; br_cond = 1'b0;
    tick();
    n_cmp++; if (pc !== 32'h204) begin n_bad++; $display("FAIL br_not_taken got=%h want=%h", pc, 32'h204); end
    go_to(32'h200);
    pc_sel = 3'd1; br_cond = 1'b1; stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_cmp++; if (pc !== 32'h200) begin n_bad++; $display("FAIL stall_hold%0d got=%h want=%h", i, pc, 32'h200); end
    end
    stall = 1'b0; br_cond = 1'b0;
  endtask

  task automatic test_jump();
    go_to(32'h1000_0000);
    pc_sel = 3'd2; inst = 32'h0000_0040;
    tick();
    n_cmp++; if (pc !== 32'h1000_0100) begin n_bad++; $display("FAIL jump got=%h want=%h", pc, 32'h1000_0100); end
    pc_sel = 3'd3; rs_val = 32'h0000_0403;
    tick();
    n_cmp++; if (pc !== 32'h0000_0400) begin n_bad++; $display("FAIL jump_reg got=%h want=%h", pc, 32'h400); end
  endtask

`ifdef PC_SEQ_RAS_EN
  task automatic test_ras();
    logic [31:0] exp_ret [4];
    exp_ret = '{32'h54, 32'h44, 32'h34, 32'h24};
    go_to(32'h10);
    for (int i = 0; i < 5; i++) begin
      pc_sel = 3'd4; inst = 32'((i + 2) * 4);   // call from 0x10*(i+1) to the next 0x10 slot
      tick();
      n_cmp++; if (ras_full !== (i >= 3)) begin n_bad++; $display("FAIL ras_full_call%0d got=%b want=%b", i, ras_full, i >= 3); end
    end
    for (int i = 0; i < 4; i++) begin
      pc_sel = 3'd5;
      tick();
      n_cmp++; if (pc !== exp_ret[i]) begin n_bad++; $display("FAIL ras_ret%0d got=%h want=%h", i, pc, exp_ret[i]); end
    end
    n_cmp++; if (ras_empty !== 1'b1) begin n_bad++; $display("FAIL ras_drained got=%b want=1", ras_empty); end
    pc_sel = 3'd5; rs_val = 32'h800;
    tick();
    n_cmp++; if (pc !== 32'h800) begin n_bad++; $display("FAIL ras_underflow_pc got=%h want=%h", pc, 32'h800); end
    n_cmp++; if (ras_err !== 1'b1) begin n_bad++; $display("FAIL ras_err_pulse got=%b want=1", ras_err); end
    pc_sel = 3'd0;
    tick();
    n_cmp++; if (ras_err !== 1'b0) begin n_bad++; $display("FAIL ras_err_clear got=%b want=0", ras_err); end
  endtask
`else
  task automatic test_noras();
    go_to(32'h40);
    pc_sel = 3'd4; inst = 32'h0000_0040;
    tick();
    n_cmp++; if (pc !== 32'h100) begin n_bad++; $display("FAIL noras_call got=%h want=%h", pc, 32'h100); end
    pc_sel = 3'd5; rs_val = 32'h300;
    tick();
    n_cmp++; if (pc !== 32'h300) begin n_bad++; $display("FAIL noras_ret got=%h want=%h", pc, 32'h300); end
    n_cmp++; if (ras_empty !== 1'b1) begin n_bad++; $display("FAIL noras_empty got=%b want=1", ras_empty); end
    n_cmp++; if (ras_err !== 1'b0) begin n_bad++; $display("FAIL noras_err got=%b want=0", ras_err); end
  endtask
`endif

  task automatic test_priority();
    go_to(32'h10);
    pc_sel = 3'd4; inst = 32'h0000_0010;       // call, pushes 0x14 when the RAS exists
    tick();
    redirect_valid = 1'b1; redirect_pc = 32'h80; stall = 1'b1; pc_sel = 3'd4;
    tick();
    n_cmp++; if (pc !== 32'h80) begin n_bad++; $display("FAIL prio_pc got=%h want=%h", pc, 32'h80); end
    n_cmp++; if (ras_empty !== m_empty()) begin n_bad++; $display("FAIL prio_empty got=%b want=%b", ras_empty, m_empty()); end
    redirect_valid = 1'b0; stall = 1'b0; pc_sel = 3'd5; rs_val = 32'h600;
    tick();
    n_cmp++; if (pc !== m_pc) begin n_bad++; $display("FAIL prio_ret got=%h want=%h", pc, m_pc); end
    pc_sel = 3'd0;
  endtask

  task automatic test_reset_midcall();
    go_to(32'h3000);
    pc_sel = 3'd4; inst = 32'h0000_0100;
    #2 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    model_reset();
    n_cmp++; if (pc !== 32'h100) begin n_bad++; $display("FAIL midreset_pc got=%h want=%h", pc, 32'h100); end
    n_cmp++; if (ras_empty !== 1'b1) begin n_bad++; $display("FAIL midreset_empty got=%b want=1", ras_empty); end
    tick();
    n_cmp++; if (pc !== m_pc) begin n_bad++; $display("FAIL midreset_first got=%h want=%h", pc, m_pc); end
    n_cmp++; if (ras_empty !== m_empty()) begin n_bad++; $display("FAIL midreset_push got=%b want=%b", ras_empty, m_empty()); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      redirect_valid = ($urandom_range(0, 15) == 0);
      redirect_pc    = $urandom;
      stall          = ($urandom_range(0, 7) == 0);
      pc_sel         = 3'($urandom_range(0, 7));
      br_cond        = 1'($urandom);
      inst           = $urandom;
      rs_val         = $urandom;
      tick();
      n_cmp++; if (pc !== m_pc) begin n_bad++; $display("FAIL rnd_pc[%0d] got=%h want=%h", i, pc, m_pc); end
      n_cmp++; if (link_pc !== m_pc + 32'd4) begin n_bad++; $display("FAIL rnd_link[%0d] got=%h want=%h", i, link_pc, m_pc + 32'd4); end
      n_cmp++; if (ras_empty !== m_empty()) begin n_bad++; $display("FAIL rnd_empty[%0d] got=%b want=%b", i, ras_empty, m_empty()); end
      n_cmp++; if (ras_full !== m_full()) begin n_bad++; $display("FAIL rnd_full[%0d] got=%b want=%b", i, ras_full, m_full()); end
      n_cmp++; if (ras_err !== m_err) begin n_bad++; $display("FAIL rnd_err[%0d] got=%b want=%b", i, ras_err, m_err); end
    end
    redirect_valid = 1'b0; stall = 1'b0; pc_sel = 3'd0;
  endtask

  initial begin
    test_reset();
    test_branch_stall();
    test_jump();
`ifdef PC_SEQ_RAS_EN
    test_ras();
`else
    test_noras();
`endif
    test_priority();
    test_reset_midcall();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
